// File: rtl/lock_entry_controller.sv
// Digital-lock code-entry sequencer: captures four digits, compares against the stored password,
// handles unlock/relock, password change and failed-attempt lockout. Optional: ENTRY_TIMEOUT_EN.
module lock_entry_controller #(
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned LOCKOUT_TICKS = 30,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter logic [19:0] DEFAULT_CODE  = 20'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        enter,
  input  logic        change_req,
  input  logic [3:0]  digit,
  output logic [19:0] entry_code,
  output logic [1:0]  digit_idx,
  output logic [2:0]  dsp_sel,
  output logic        unlocked,
  output logic        locked_out,
  output logic [2:0]  fail_cnt,
  output logic [3:0]  led
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_NEW_ENTRY,
    S_LOCKOUT
  } state_t;

  localparam logic [2:0] DSP_CLOSED = 3'b100;
  localparam logic [2:0] DSP_OPEN   = 3'b101;
  localparam logic [2:0] DSP_LOCK   = 3'b111;
  localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAILS);
  localparam logic [7:0] LOCK_LIMIT = 8'(LOCKOUT_TICKS);

  if (MAX_FAILS < 1 || MAX_FAILS > 7 || LOCKOUT_TICKS < 1 || LOCKOUT_TICKS > 255 ||
      TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_params
    $error("lock_entry_controller: parameter out of range");
  end

  state_t      state_q;
  state_t      state_d;
  logic [19:0] password_q;
  logic [7:0]  lock_cnt_q;
  logic [7:0]  lock_cnt_inc;
  logic        capture;
  logic        last_digit;
  logic        code_match;
  logic        lock_done;
  logic        timeout_hit;
  logic [2:0]  fail_next;
  logic [19:0] capture_code;
  logic [2:0]  dsp_sel_d;
  logic        unlocked_d;
  logic        locked_out_d;
  logic [3:0]  led_d;

  assign capture      = enter && (state_q == S_IDLE || state_q == S_ENTRY ||
                                  state_q == S_NEW_ENTRY);
  assign last_digit   = (digit_idx == 2'd3);
  assign code_match   = (entry_code == password_q);
  assign fail_next    = (fail_cnt >= FAIL_LIMIT) ? fail_cnt : fail_cnt + 3'd1;
  assign lock_cnt_inc = lock_cnt_q + 8'd1;
  assign lock_done    = (state_q == S_LOCKOUT) && tick && (lock_cnt_inc == LOCK_LIMIT);

  // A fresh entry from IDLE starts from a blank code so stale slots never reach the compare.
  always_comb begin
    capture_code = (state_q == S_IDLE) ? 20'h0 : entry_code;
    capture_code[5*digit_idx +: 5] = {1'b0, digit};
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT_TICKS);

  logic [7:0] idle_cnt_q;
  logic [7:0] idle_cnt_inc;
  logic       in_entry;

  assign in_entry     = (state_q == S_ENTRY) || (state_q == S_NEW_ENTRY);
  assign idle_cnt_inc = idle_cnt_q + 8'd1;
  // enter on the expiring tick wins: the digit is taken and the counter restarts
  assign timeout_hit  = in_entry && tick && !enter && (idle_cnt_inc == IDLE_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= 8'h0;
    end else if (!in_entry || enter || timeout_hit) begin
      idle_cnt_q <= 8'h0;
    end else if (tick) begin
      idle_cnt_q <= idle_cnt_inc;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (capture) state_d = S_ENTRY;
      S_ENTRY: begin
        if (timeout_hit)                state_d = S_IDLE;
        else if (capture && last_digit) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (code_match)                   state_d = S_UNLOCKED;
        else if (fail_next == FAIL_LIMIT) state_d = S_LOCKOUT;
        else                              state_d = S_IDLE;
      end
      S_UNLOCKED:  if (enter) state_d = change_req ? S_NEW_ENTRY : S_IDLE;
      S_NEW_ENTRY: if (timeout_hit || (capture && last_digit)) state_d = S_IDLE;
      S_LOCKOUT:   if (lock_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    led_d        = 4'b0001;
    unlocked_d   = 1'b0;
    locked_out_d = 1'b0;
    dsp_sel_d    = dsp_sel;
    case (state_d)
      S_IDLE: begin
        led_d     = 4'b0001;
        dsp_sel_d = DSP_CLOSED;
      end
      S_ENTRY, S_CHECK: begin
        led_d = 4'b0010;
        if (capture) dsp_sel_d = {1'b0, digit_idx};
      end
      S_UNLOCKED: begin
        led_d      = 4'b1000;
        unlocked_d = 1'b1;
        dsp_sel_d  = DSP_OPEN;
      end
      S_NEW_ENTRY: begin
        led_d      = 4'b0100;
        unlocked_d = 1'b1;
        if (capture) dsp_sel_d = {1'b0, digit_idx};
      end
      S_LOCKOUT: begin
        led_d        = 4'b1111;
        locked_out_d = 1'b1;
        dsp_sel_d    = DSP_LOCK;
      end
      default: begin
        led_d     = 4'b0001;
        dsp_sel_d = DSP_CLOSED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led        <= 4'b0001;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      dsp_sel    <= DSP_CLOSED;
    end else begin
      led        <= led_d;
      unlocked   <= unlocked_d;
      locked_out <= locked_out_d;
      dsp_sel    <= dsp_sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_code <= 20'h0;
      digit_idx  <= 2'd0;
      fail_cnt   <= 3'd0;
      lock_cnt_q <= 8'h0;
      password_q <= DEFAULT_CODE;
    end else begin
      if (capture) begin
        entry_code <= capture_code;
        digit_idx  <= digit_idx + 2'd1;
        if (state_q == S_NEW_ENTRY && last_digit) password_q <= capture_code;
      end else if (timeout_hit || (state_q == S_UNLOCKED && enter)) begin
        entry_code <= 20'h0;
        digit_idx  <= 2'd0;
      end

      if (state_q == S_CHECK) begin
        fail_cnt   <= code_match ? 3'd0 : fail_next;
        lock_cnt_q <= 8'h0;
      end else if (lock_done) begin
        fail_cnt   <= 3'd0;
        lock_cnt_q <= 8'h0;
      end else if (state_q == S_LOCKOUT && tick) begin
        lock_cnt_q <= lock_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_lock_entry_controller.sv
// Directed self-checking bench for lock_entry_controller with default parameters.
module tb_lock_entry_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        enter;
  logic        change_req;
  logic [3:0]  digit;
  logic [19:0] entry_code;
  logic [1:0]  digit_idx;
  logic [2:0]  dsp_sel;
  logic        unlocked;
  logic        locked_out;
  logic [2:0]  fail_cnt;
  logic [3:0]  led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lock_entry_controller dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .enter      (enter),
    .change_req (change_req),
    .digit      (digit),
    .entry_code (entry_code),
    .digit_idx  (digit_idx),
    .dsp_sel    (dsp_sel),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt),
    .led        (led)
  );

  // Drive for one clock edge; on return the outputs reflect that edge.
  task automatic pulse(input logic [3:0] d, input logic e, input logic cr, input logic t);
    @(negedge clk);
    digit = d; enter = e; change_req = cr; tick = t;
    @(negedge clk);
    enter = 1'b0; change_req = 1'b0; tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    pulse(d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic test_reset;
    rst = 1'b1; tick = 1'b0; enter = 1'b0; change_req = 1'b0; digit = 4'h0;
    repeat (2) @(negedge clk);
    checks++; if (led !== 4'b0001) begin errors++; $display("FAIL rst_led got %b want 0001", led); end
    checks++; if (dsp_sel !== 3'b100) begin errors++; $display("FAIL rst_dsp got %b want 100", dsp_sel); end
    checks++; if ({unlocked, locked_out, fail_cnt, digit_idx} !== 7'b0) begin
      errors++; $display("FAIL rst_flags got %b want 0000000", {unlocked, locked_out, fail_cnt, digit_idx});
    end
    checks++; if (entry_code !== 20'h0) begin errors++; $display("FAIL rst_code got %h want 00000", entry_code); end
    rst = 1'b0;
  endtask

  task automatic test_unlock_default;
    press(4'h0);
    checks++; if (digit_idx !== 2'd1) begin errors++; $display("FAIL d1_idx got %0d want 1", digit_idx); end
    checks++; if (led !== 4'b0010) begin errors++; $display("FAIL d1_led got %b want 0010", led); end
    press(4'h0);
    checks++; if (dsp_sel !== 3'b001) begin errors++; $display("FAIL d2_dsp got %b want 001", dsp_sel); end
    press(4'h0); press(4'h0);
    checks++; if ({led, digit_idx, dsp_sel} !== {4'b0010, 2'd0, 3'b011}) begin
      errors++; $display("FAIL check_state got %b want 0010_00_011", {led, digit_idx, dsp_sel});
    end
    @(negedge clk);
    checks++; if ({unlocked, led, dsp_sel, fail_cnt} !== {1'b1, 4'b1000, 3'b101, 3'd0}) begin
      errors++; $display("FAIL unlock0 got %b want 1_1000_101_000", {unlocked, led, dsp_sel, fail_cnt});
    end
  endtask

  task automatic test_change_password;
    pulse(4'h0, 1'b1, 1'b1, 1'b0);
    checks++; if ({led, unlocked, digit_idx} !== {4'b0100, 1'b1, 2'd0}) begin
      errors++; $display("FAIL newentry got %b want 0100_1_00", {led, unlocked, digit_idx});
    end
    checks++; if (entry_code !== 20'h0) begin errors++; $display("FAIL newentry_code got %h want 00000", entry_code); end
    press(4'h1); press(4'h2); press(4'h3);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL newentry_unl got %b want 1", unlocked); end
    press(4'h4);
    checks++; if ({led, unlocked, dsp_sel} !== {4'b0001, 1'b0, 3'b100}) begin
      errors++; $display("FAIL pwset got %b want 0001_0_100", {led, unlocked, dsp_sel});
    end
    checks++; if (entry_code !== 20'h20C41) begin errors++; $display("FAIL pwset_code got %h want 20c41", entry_code); end
    code4(4'h1, 4'h2, 4'h3, 4'h4);
    checks++; if (entry_code !== 20'h20C41) begin errors++; $display("FAIL newpw_code got %h want 20c41", entry_code); end
    @(negedge clk);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL newpw_unlock got %b want 1", unlocked); end
    press(4'h0);
    checks++; if ({led, unlocked, entry_code} !== {4'b0001, 1'b0, 20'h0}) begin
      errors++; $display("FAIL relock got %b_%b_%h want 0001_0_00000", led, unlocked, entry_code);
    end
    code4(4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    checks++; if ({fail_cnt, led, locked_out} !== {3'd1, 4'b0001, 1'b0}) begin
      errors++; $display("FAIL oldpw_fail got %b want 001_0001_0", {fail_cnt, led, locked_out});
    end
  endtask

  task automatic test_success_resets;
    code4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    checks++; if ({fail_cnt, unlocked} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL right_clr got %b want 000_1", {fail_cnt, unlocked});
    end
    press(4'h0);
    code4(4'h9, 4'h9, 4'h9, 4'h9);
    @(negedge clk);
    checks++; if (fail_cnt !== 3'd1) begin errors++; $display("FAIL wrong_again got %0d want 1", fail_cnt); end
  endtask

  task automatic test_lockout;
    code4(4'h5, 4'h5, 4'h5, 4'h5);
    @(negedge clk);
    checks++; if ({fail_cnt, locked_out, led} !== {3'd2, 1'b0, 4'b0001}) begin
      errors++; $display("FAIL fail2 got %b want 010_0_0001", {fail_cnt, locked_out, led});
    end
    code4(4'hF, 4'hF, 4'hF, 4'hF);
    @(negedge clk);
    checks++; if ({fail_cnt, locked_out, led, dsp_sel} !== {3'd3, 1'b1, 4'b1111, 3'b111}) begin
      errors++; $display("FAIL lockout got %b want 011_1_1111_111", {fail_cnt, locked_out, led, dsp_sel});
    end
    press(4'h5);
    checks++; if ({led, digit_idx} !== {4'b1111, 2'd0}) begin
      errors++; $display("FAIL lock_ignore got %b want 1111_00", {led, digit_idx});
    end
    ticks(28);
    pulse(4'h3, 1'b1, 1'b0, 1'b1);
    checks++; if ({locked_out, digit_idx} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL lock_29 got %b want 1_00", {locked_out, digit_idx});
    end
    ticks(1);
    checks++; if ({locked_out, led, fail_cnt, dsp_sel} !== {1'b0, 4'b0001, 3'd0, 3'b100}) begin
      errors++; $display("FAIL lock_end got %b want 0_0001_000_100", {locked_out, led, fail_cnt, dsp_sel});
    end
  endtask

  task automatic test_idle_entry;
    code4(4'h7, 4'h7, 4'h7, 4'h7);
    @(negedge clk);
    press(4'h1); press(4'h2);
`ifdef ENTRY_TIMEOUT_EN
    ticks(9);
    checks++; if ({led, digit_idx} !== {4'b0010, 2'd2}) begin
      errors++; $display("FAIL to_9 got %b want 0010_10", {led, digit_idx});
    end
    ticks(1);
    checks++; if ({led, digit_idx, entry_code, fail_cnt} !== {4'b0001, 2'd0, 20'h0, 3'd1}) begin
      errors++; $display("FAIL to_abort got %b_%0d_%h_%0d want 0001_0_00000_1", led, digit_idx, entry_code, fail_cnt);
    end
    press(4'h1); press(4'h2);
    ticks(9);
    pulse(4'h3, 1'b1, 1'b0, 1'b1);
    checks++; if ({led, digit_idx} !== {4'b0010, 2'd3}) begin
      errors++; $display("FAIL to_enter_wins got %b want 0010_11", {led, digit_idx});
    end
`else
    ticks(20);
    checks++; if ({led, digit_idx, entry_code} !== {4'b0010, 2'd2, 20'h00041}) begin
      errors++; $display("FAIL persist got %b_%0d_%h want 0010_2_00041", led, digit_idx, entry_code);
    end
    press(4'h3);
`endif
    press(4'h4);
    @(negedge clk);
    checks++; if ({unlocked, fail_cnt} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL idle_unlock got %b want 1_000", {unlocked, fail_cnt});
    end
    press(4'h0);
  endtask

  task automatic test_reset_mid_entry;
    press(4'h1); press(4'h2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if ({led, digit_idx, entry_code, fail_cnt} !== {4'b0001, 2'd0, 20'h0, 3'd0}) begin
      errors++; $display("FAIL midrst got %b_%0d_%h_%0d want 0001_0_00000_0", led, digit_idx, entry_code, fail_cnt);
    end
    code4(4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL default_pw got %b want 1", unlocked); end
  endtask

  initial begin
    test_reset;
    test_unlock_default;
    test_change_password;
    test_success_resets;
    test_lockout;
    test_idle_entry;
    test_reset_mid_entry;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
